phase_cordic4: RTL and testbench

//  Upstream of the phase-difference stage: converts four hydrophone I/Q pairs into four signed phases.

---
 rtl/usbl_phase_pkg.sv | 54 +++++
 rtl/cordic_vec_step.sv | 37 +++
 rtl/phase_cordic4.sv | 195 +++++++++++++++++++
 tb/tb_phase_cordic4.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbl_phase_pkg.sv
// Shared constants for the hydrophone phase front end: phase scale,
// CORDIC arctangent table, FSM state encoding and phase saturation helper.
package usbl_phase_pkg;

  // z accumulator width (signed)
  localparam int ZW = 18;

  localparam logic signed [ZW-1:0] PHASE_PI_2 = 18'sd16384;
  localparam logic signed [ZW-1:0] PHASE_MAX  = 18'sd32767;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_ITER  = 3'd2;
  localparam logic [2:0] ST_STORE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // atan(2^-i) scaled so that pi/2 maps to 16384
  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
    logic signed [ZW-1:0] v;
    case (idx)
      4'd0:    v = 18'sd8192;
      4'd1:    v = 18'sd4836;
      4'd2:    v = 18'sd2555;
      4'd3:    v = 18'sd1297;
      4'd4:    v = 18'sd651;
      4'd5:    v = 18'sd326;
      4'd6:    v = 18'sd163;
      4'd7:    v = 18'sd81;
      4'd8:    v = 18'sd41;
      4'd9:    v = 18'sd20;
      4'd10:   v = 18'sd10;
      4'd11:   v = 18'sd5;
      4'd12:   v = 18'sd3;
      4'd13:   v = 18'sd1;
      default: v = 18'sd0;
    endcase
    return v;
  endfunction

  // Clamp the accumulated angle to the symmetric range [-32767, +32767]
  function automatic logic signed [15:0] sat_phase(input logic signed [ZW-1:0] z);
    logic signed [15:0] r;
    if (z > PHASE_MAX) begin
      r = 16'sd32767;
    end else if (z < -PHASE_MAX) begin
      r = -16'sd32767;
    end else begin
      r = z[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cordic_vec_step.sv
// One combinational CORDIC vectoring micro-rotation: drives y toward zero
// and accumulates the rotated angle into z.
module cordic_vec_step
  import usbl_phase_pkg::*;
#(
  parameter int W = 18
) (
  input  logic signed [W-1:0]  i_x,
  input  logic signed [W-1:0]  i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic        [3:0]    i_i,
  output logic signed [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [W-1:0]  w_xs;
  logic signed [W-1:0]  w_ys;
  logic signed [ZW-1:0] w_a;

  // Simultaneous x/y/z update; direction chosen from the sign of y
  always_comb begin
    w_xs = i_x >>> i_i;
    w_ys = i_y >>> i_i;
    w_a  = atan_lut(i_i);
    if (i_y[W-1]) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - w_a;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + w_a;
    end
  end

endmodule

// File: rtl/phase_cordic4.sv
// Four-channel atan2(Q,I) phase extractor sharing one iterative CORDIC engine.
// Optional feature macro: PHASE_CORDIC_OVERRUN_EN adds a sticky overrun flag
// for strobes that arrive while a computation is in flight.
module phase_cordic4
  import usbl_phase_pkg::*;
#(
  parameter int ITER = 14,
  parameter int IW   = 16,
  parameter int GW   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [IW-1:0] i1,
  input  logic signed [IW-1:0] i2,
  input  logic signed [IW-1:0] i3,
  input  logic signed [IW-1:0] i4,
  input  logic signed [IW-1:0] q1,
  input  logic signed [IW-1:0] q2,
  input  logic signed [IW-1:0] q3,
  input  logic signed [IW-1:0] q4,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [15:0]   phase1,
  output logic signed [15:0]   phase2,
  output logic signed [15:0]   phase3,
  output logic signed [15:0]   phase4
`ifdef PHASE_CORDIC_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam int W = IW + GW;

  logic [2:0]           r_state;
  logic [1:0]           r_ch;
  logic [3:0]           r_iter;
  logic signed [IW-1:0] r_i [4];
  logic signed [IW-1:0] r_q [4];
  logic signed [W-1:0]  r_x;
  logic signed [W-1:0]  r_y;
  logic signed [ZW-1:0] r_z;
  logic                 r_force;
  logic signed [15:0]   r_force_val;
  logic signed [15:0]   r_res [4];
  logic signed [15:0]   r_phase [4];
  logic                 r_busy;
  logic                 r_out_valid;

  logic signed [W-1:0]  w_ci;
  logic signed [W-1:0]  w_cq;
  logic signed [W-1:0]  w_pre_x;
  logic signed [W-1:0]  w_pre_y;
  logic signed [ZW-1:0] w_pre_z;
  logic signed [W-1:0]  w_nx;
  logic signed [W-1:0]  w_ny;
  logic signed [ZW-1:0] w_nz;

  // Channel select plus quadrant pre-rotation into the +/-pi/2 convergence range
  always_comb begin
    w_ci    = {{GW{r_i[r_ch][IW-1]}}, r_i[r_ch]};
    w_cq    = {{GW{r_q[r_ch][IW-1]}}, r_q[r_ch]};
    w_pre_x = w_ci;
    w_pre_y = w_cq;
    w_pre_z = '0;
    if (!w_ci[W-1]) begin
      w_pre_x = w_ci;
      w_pre_y = w_cq;
      w_pre_z = '0;
    end else if (!w_cq[W-1]) begin
      w_pre_x = w_cq;
      w_pre_y = -w_ci;
      w_pre_z = PHASE_PI_2;
    end else begin
      w_pre_x = -w_cq;
      w_pre_y = w_ci;
      w_pre_z = -PHASE_PI_2;
    end
  end

  cordic_vec_step #(.W(W)) u_step (
    .i_x (r_x),
    .i_y (r_y),
    .i_z (r_z),
    .i_i (r_iter),
    .o_x (w_nx),
    .o_y (w_ny),
    .o_z (w_nz)
  );

  // Sequencer: input latch, per-channel PRE/ITER/STORE, then publish all four phases
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_ch        <= 2'd0;
      r_iter      <= 4'd0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_force     <= 1'b0;
      r_force_val <= 16'sd0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_i[k]     <= '0;
        r_q[k]     <= '0;
        r_res[k]   <= 16'sd0;
        r_phase[k] <= 16'sd0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_i[0]  <= i1;  r_i[1] <= i2;  r_i[2] <= i3;  r_i[3] <= i4;
            r_q[0]  <= q1;  r_q[1] <= q2;  r_q[2] <= q3;  r_q[3] <= q4;
            r_busy  <= 1'b1;
            r_ch    <= 2'd0;
            r_state <= ST_PRE;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_PRE: begin
          r_x     <= w_pre_x;
          r_y     <= w_pre_y;
          r_z     <= w_pre_z;
          // On-axis inputs (Q==0) get an exact answer: 0, or +pi saturated for I<0
          r_force     <= (w_cq == '0);
          r_force_val <= w_ci[W-1] ? 16'sd32767 : 16'sd0;
          r_iter  <= 4'd0;
          r_state <= ST_ITER;
        end
        ST_ITER: begin
          r_x    <= w_nx;
          r_y    <= w_ny;
          r_z    <= w_nz;
          r_iter <= r_iter + 4'd1;
          if (r_iter == 4'(ITER - 1)) begin
            r_state <= ST_STORE;
          end else begin
            r_state <= ST_ITER;
          end
        end
        ST_STORE: begin
          r_res[r_ch] <= r_force ? r_force_val : sat_phase(r_z);
          if (r_ch == 2'd3) begin
            r_state <= ST_DONE;
          end else begin
            r_ch    <= r_ch + 2'd1;
            r_state <= ST_PRE;
          end
        end
        ST_DONE: begin
          r_out_valid <= 1'b1;
          for (int k = 0; k < 4; k++) begin
            r_phase[k] <= r_res[k];
          end
          r_ch    <= 2'd0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PHASE_CORDIC_OVERRUN_EN
  logic r_overrun;

  // Sticky flag for strobes dropped because the engine was still working
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overrun <= 1'b0;
    end else if (in_valid && r_busy && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign overrun = r_overrun;
`endif

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign phase1    = r_phase[0];
  assign phase2    = r_phase[1];
  assign phase3    = r_phase[2];
  assign phase4    = r_phase[3];

endmodule

// File: tb/tb_phase_cordic4.sv
// Directed self-checking bench for phase_cordic4.
module tb_phase_cordic4;

  logic clock;
  logic reset;
  logic in_valid;
  logic signed [15:0] i1, i2, i3, i4, q1, q2, q3, q4;
  logic busy, out_valid;
  logic signed [15:0] phase1, phase2, phase3, phase4;
`ifdef PHASE_CORDIC_OVERRUN_EN
  logic overrun;
`endif

  int n_vec;
  int n_err;

  phase_cordic4 dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .i1        (i1),
    .i2        (i2),
    .i3        (i3),
    .i4        (i4),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .q4        (q4),
    .busy      (busy),
    .out_valid (out_valid),
    .phase1    (phase1),
    .phase2    (phase2),
    .phase3    (phase3),
    .phase4    (phase4)
`ifdef PHASE_CORDIC_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_inputs(input int a1, input int b1, input int a2, input int b2,
                            input int a3, input int b3, input int a4, input int b4);
    i1 = 16'(a1); q1 = 16'(b1);
    i2 = 16'(a2); q2 = 16'(b2);
    i3 = 16'(a3); q3 = 16'(b3);
    i4 = 16'(a4); q4 = 16'(b4);
  endtask

  // Pulse in_valid for one edge, then count edges until out_valid (-1 on timeout)
  task automatic run_frame(output int lat);
    lat = -1;
    @(negedge clock);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
    n_vec++;
    if (phase1 !== 16'sd0 || phase2 !== 16'sd0 || phase3 !== 16'sd0 || phase4 !== 16'sd0) begin
      n_err++;
      $display("FAIL reset_phase: %0d %0d %0d %0d, required all 0", phase1, phase2, phase3, phase4);
    end
`ifdef PHASE_CORDIC_OVERRUN_EN
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overrun: got %b, required 0", overrun);
    end
`endif
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_axis();
    int lat;
    logic signed [15:0] ph [4];
    set_inputs(16384, 0, 16384, 0, 16384, 0, 16384, 0);
    run_frame(lat);
    n_vec++;
    if (lat !== 65) begin
      n_err++;
      $display("FAIL axis_latency: got %0d cycles, required 65", lat);
    end
    ph = '{phase1, phase2, phase3, phase4};
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (int'(ph[k]) > 2 || int'(ph[k]) < -2) begin
        n_err++;
        $display("FAIL axis_phase%0d: got %0d, required 0 +/-2", k + 1, ph[k]);
      end
    end
    @(posedge clock);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL axis_pulse: out_valid=%b busy=%b one cycle later, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_quadrants();
    int lat;
    int exp_ph [4];
    logic signed [15:0] ph [4];
    exp_ph = '{16384, -16384, 8192, 24576};
    set_inputs(0, 16384, 0, -16384, 11585, 11585, -11585, 11585);
    run_frame(lat);
    n_vec++;
    if (lat !== 65) begin
      n_err++;
      $display("FAIL quad_latency: got %0d cycles, required 65", lat);
    end
    ph = '{phase1, phase2, phase3, phase4};
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (int'(ph[k]) - exp_ph[k] > 3 || int'(ph[k]) - exp_ph[k] < -3) begin
        n_err++;
        $display("FAIL quad_phase%0d: got %0d, required %0d +/-3", k + 1, ph[k], exp_ph[k]);
      end
    end
  endtask

  task automatic test_edges();
    int lat;
    set_inputs(-16384, 0, 0, 0, -16384, -1, 5, 0);
    run_frame(lat);
    n_vec++;
    if (lat !== 65) begin
      n_err++;
      $display("FAIL edge_latency: got %0d cycles, required 65", lat);
    end
    n_vec++;
    if (phase1 !== 16'sd32767) begin
      n_err++;
      $display("FAIL edge_neg_axis: got %0d, required 32767", phase1);
    end
    n_vec++;
    if (phase2 !== 16'sd0) begin
      n_err++;
      $display("FAIL edge_zero: got %0d, required 0", phase2);
    end
    n_vec++;
    if (int'(phase3) > -32764) begin
      n_err++;
      $display("FAIL edge_near_pi: got %0d, required -32767 +/-3", phase3);
    end
    n_vec++;
    if (phase4 !== 16'sd0) begin
      n_err++;
      $display("FAIL edge_small_pos: got %0d, required 0", phase4);
    end
  endtask

  task automatic test_overrun();
    int lat;
    int cnt;
    int exp_ph [4];
    logic signed [15:0] ph [4];
    exp_ph = '{16384, -16384, 8192, 24576};
    lat = -1;
    cnt = 0;
    ph = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};
    set_inputs(0, 16384, 0, -16384, 11585, 11585, -11585, 11585);
    @(negedge clock);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      if (n == 10) begin
        set_inputs(16384, 0, 16384, 0, 16384, 0, 16384, 0);
        in_valid = 1'b1;
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      if (n == 30) begin
        n_vec++;
        if (busy !== 1'b1 || phase1 !== 16'sd32767 || phase2 !== 16'sd0) begin
          n_err++;
          $display("FAIL hold_midrun: busy=%b phase1=%0d phase2=%0d, required 1 32767 0", busy, phase1, phase2);
        end
      end
`ifdef PHASE_CORDIC_OVERRUN_EN
      if (n == 11) begin
        n_vec++;
        if (overrun !== 1'b1) begin
          n_err++;
          $display("FAIL overrun_set: got %b, required 1", overrun);
        end
      end
`endif
      if (out_valid) begin
        cnt++;
        if (lat < 0) begin
          lat = n;
          ph = '{phase1, phase2, phase3, phase4};
        end
      end
    end
    n_vec++;
    if (cnt !== 1 || lat !== 65) begin
      n_err++;
      $display("FAIL overrun_pulses: %0d pulses first at %0d, required 1 at 65", cnt, lat);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (int'(ph[k]) - exp_ph[k] > 3 || int'(ph[k]) - exp_ph[k] < -3) begin
        n_err++;
        $display("FAIL overrun_phase%0d: got %0d, required %0d +/-3", k + 1, ph[k], exp_ph[k]);
      end
    end
`ifdef PHASE_CORDIC_OVERRUN_EN
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
`endif
  endtask

  task automatic test_midreset();
    int lat;
    int cnt;
    cnt = 0;
    set_inputs(0, 16384, 0, -16384, 11585, 11585, -11585, 11585);
    @(negedge clock);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || out_valid !== 1'b0 ||
        phase1 !== 16'sd0 || phase2 !== 16'sd0 || phase3 !== 16'sd0 || phase4 !== 16'sd0) begin
      n_err++;
      $display("FAIL midreset_clear: busy=%b ov=%b ph=%0d %0d %0d %0d, required all 0",
               busy, out_valid, phase1, phase2, phase3, phase4);
    end
`ifdef PHASE_CORDIC_OVERRUN_EN
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_overrun: got %b, required 0", overrun);
    end
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(posedge clock);
      #1;
      if (out_valid) cnt++;
    end
    n_vec++;
    if (cnt !== 0) begin
      n_err++;
      $display("FAIL midreset_no_pulse: got %0d pulses, required 0", cnt);
    end
    set_inputs(-16384, 0, 0, 0, 16384, 0, 0, -16384);
    run_frame(lat);
    n_vec++;
    if (lat !== 65) begin
      n_err++;
      $display("FAIL midreset_rerun_latency: got %0d cycles, required 65", lat);
    end
    n_vec++;
    if (phase1 !== 16'sd32767 || phase2 !== 16'sd0 || phase3 !== 16'sd0 ||
        int'(phase4) + 16384 > 3 || int'(phase4) + 16384 < -3) begin
      n_err++;
      $display("FAIL midreset_rerun_phase: got %0d %0d %0d %0d, required 32767 0 0 -16384",
               phase1, phase2, phase3, phase4);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_axis();
    test_quadrants();
    test_edges();
    test_overrun();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
